// File: rtl/mseq_ctrl_pkg.sv
// Shared definitions for the micro-engine instruction sequencer:
// class codes, FSM state encoding and default widths.
package mseq_ctrl_pkg;

    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH  = 6;
    localparam int DEF_TMO_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH   = 16;

    localparam logic [1:0] CLS_BR  = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_ILL = 2'b11;

    // state       | meaning
    // ST_IDLE     | out of reset, waiting for start
    // ST_FETCH    | imem_req held until imem_ack
    // ST_DECODE   | one cycle: resolve branch or dispatch to a unit
    // ST_WAIT_ALU | waiting for alu_done, watchdog running
    // ST_WAIT_MEM | waiting for mem_done, watchdog running
    // ST_HALT     | stopped on illegal/timeout, start restarts at PC 0
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_ALU,
        ST_WAIT_MEM,
        ST_HALT
    } state_e;

endpackage

// File: rtl/mseq_ctrl_if.sv
// Instruction-memory fetch and ALU/memory dispatch handshakes of the sequencer.
interface mseq_ctrl_if
    import mseq_ctrl_pkg::*;
#(
    parameter int IW = DEF_INSTR_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH
) ();

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          alu_start;
    logic          alu_done;
    logic          mem_start;
    logic          mem_done;

    modport master (
        output imem_req, imem_addr, alu_start, mem_start,
        input  imem_ack, imem_data, alu_done, mem_done
    );

    modport slave (
        input  imem_req, imem_addr, alu_start, mem_start,
        output imem_ack, imem_data, alu_done, mem_done
    );

endinterface

// File: rtl/mseq_ctrl_classify.sv
// Combinational instruction classifier: decodes the class field and
// extracts the branch target.
module mseq_classify
    import mseq_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0] ir_i,
    output logic                   is_br_o,
    output logic                   is_alu_o,
    output logic                   is_mem_o,
    output logic                   is_ill_o,
    output logic [ADDR_WIDTH-1:0]  br_target_o
);

    logic [1:0] cls;
    logic       unused_bits;

    assign cls         = ir_i[INSTR_WIDTH-1 -: 2];
    assign is_br_o     = (cls == CLS_BR);
    assign is_alu_o    = (cls == CLS_ALU);
    assign is_mem_o    = (cls == CLS_MEM);
    assign is_ill_o    = (cls == CLS_ILL);
    assign br_target_o = ir_i[ADDR_WIDTH-1:0];

    // Operand bits belong to the execution units, not the sequencer.
    assign unused_bits = ^ir_i[INSTR_WIDTH-3:ADDR_WIDTH];

endmodule

// File: rtl/mseq_ctrl.sv
// Instruction sequencer: owns the PC, fetches over imem req/ack, resolves
// branches locally and dispatches ALU/memory work with a watchdog.
module mseq_ctrl
    import mseq_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int TMO_WIDTH   = DEF_TMO_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    mseq_ctrl_if.master            bus,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   busy_o,
    output logic                   halted_o,
    output logic                   illegal_o,
    output logic                   timeout_o,
    output logic [CNT_WIDTH-1:0]   icount_o
);

    // Watchdog fires on the cycle the counter would reach all-ones.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_WIDTH-1:0]   icount_q, icount_d, icount_inc;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;

    logic                   imem_req, alu_start, mem_start, wait_done;
    logic                   is_br, is_alu, is_mem, is_ill;
    logic [ADDR_WIDTH-1:0]  br_target;

    mseq_classify #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_classify (
        .ir_i        (ir_q),
        .is_br_o     (is_br),
        .is_alu_o    (is_alu),
        .is_mem_o    (is_mem),
        .is_ill_o    (is_ill),
        .br_target_o (br_target)
    );

    assign icount_inc = (&icount_q) ? icount_q : icount_q + 1'b1;
    assign wait_done  = (state_q == ST_WAIT_ALU) ? bus.alu_done : bus.mem_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            icount_q  <= '0;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            icount_q  <= icount_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        icount_d  = icount_q;
        tmo_d     = tmo_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        mem_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_br) begin
                    pc_d     = br_target;
                    icount_d = icount_inc;
                    state_d  = ST_FETCH;
                end else if (is_alu) begin
                    alu_start = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_WAIT_ALU;
                end else if (is_mem) begin
                    mem_start = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_WAIT_MEM;
                end else if (is_ill) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WAIT_ALU, ST_WAIT_MEM: begin
                if (wait_done) begin
                    pc_d     = pc_q + 1'b1;
                    icount_d = icount_inc;
                    state_d  = ST_FETCH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (start_i) begin
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    pc_d      = '0;
                    icount_d  = '0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc_q;
    assign bus.alu_start = alu_start;
    assign bus.mem_start = mem_start;

    assign instr_o   = ir_q;
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted_o  = (state_q == ST_HALT);
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign icount_o  = icount_q;

endmodule

// File: tb/tb_mseq_ctrl.sv
// Directed bench for mseq_ctrl: combinational imem model with same-cycle ack,
// delay-programmable ALU/memory responders, hand-computed expectations.
module tb_mseq_ctrl;
    import mseq_ctrl_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic [DEF_INSTR_WIDTH-1:0] instr;
    logic                       busy, halted, illegal, timeout;
    logic [DEF_CNT_WIDTH-1:0]   icount;

    logic                       ack_en = 1'b1;
    logic                       alu_stray = 1'b0, mem_stray = 1'b0;
    logic                       alu_resp = 1'b0, mem_resp = 1'b0;
    int                         alu_dly = 1, mem_dly = 1;
    logic [DEF_INSTR_WIDTH-1:0] imem [64];

    int fetch_log [$];
    int alu_n = 0, mem_n = 0;
    int n_checks = 0, n_pass = 0;

    mseq_ctrl_if bus ();

    mseq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .bus       (bus),
        .instr_o   (instr),
        .busy_o    (busy),
        .halted_o  (halted),
        .illegal_o (illegal),
        .timeout_o (timeout),
        .icount_o  (icount)
    );

    always #5 clk = ~clk;

    assign bus.imem_ack  = bus.imem_req & ack_en;
    assign bus.imem_data = imem[bus.imem_addr];
    assign bus.alu_done  = alu_resp | alu_stray;
    assign bus.mem_done  = mem_resp | mem_stray;

    // Unit responders (done N cycles after start, 0 = never) and fetch/strobe monitor.
    initial begin
        int alu_cnt, mem_cnt;
        alu_cnt = 0;
        mem_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                alu_cnt  = 0;
                mem_cnt  = 0;
                alu_resp = 1'b0;
                mem_resp = 1'b0;
                alu_n    = 0;
                mem_n    = 0;
                fetch_log.delete();
            end else begin
                if (bus.alu_start) begin
                    alu_cnt  = alu_dly;
                    alu_resp = 1'b0;
                    alu_n++;
                end else if (alu_cnt > 0) begin
                    alu_cnt--;
                    alu_resp = (alu_cnt == 0);
                end else begin
                    alu_resp = 1'b0;
                end
                if (bus.mem_start) begin
                    mem_cnt  = mem_dly;
                    mem_resp = 1'b0;
                    mem_n++;
                end else if (mem_cnt > 0) begin
                    mem_cnt--;
                    mem_resp = (mem_cnt == 0);
                end else begin
                    mem_resp = 1'b0;
                end
                if (bus.imem_req && bus.imem_ack)
                    fetch_log.push_back(int'(bus.imem_addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int log_at(input int i);
        return (i < fetch_log.size()) ? fetch_log[i] : -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        ack_en    = 1'b1;
        alu_stray = 1'b0;
        mem_stray = 1'b0;
        alu_dly   = 1;
        mem_dly   = 1;
        for (int i = 0; i < 64; i++) imem[i] = 32'hC000_0000;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        chk(tag, halted, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_halted"},  halted, 0);
        chk({tag, "_req"},     bus.imem_req, 0);
        chk({tag, "_addr"},    bus.imem_addr, 0);
        chk({tag, "_alu_st"},  bus.alu_start, 0);
        chk({tag, "_mem_st"},  bus.mem_start, 0);
        chk({tag, "_instr"},   instr, 0);
        chk({tag, "_icount"},  icount, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int n;

        // 1: ALU then MEM, done 2 cycles after each start
        do_reset();
        chk_all_zero("rst");
        imem[0] = 32'h4000_0000;
        imem[1] = 32'h8000_0000;
        alu_dly = 2;
        mem_dly = 2;
        pulse_start();
        wait_halt("t1_halt", 40);
        chk("t1_nfetch", fetch_log.size(), 3);
        chk("t1_addr0", log_at(0), 0);
        chk("t1_addr1", log_at(1), 1);
        chk("t1_addr2", log_at(2), 2);
        chk("t1_alu_n", alu_n, 1);
        chk("t1_mem_n", mem_n, 1);
        chk("t1_icount", icount, 2);

        // 2: branch to 37
        do_reset();
        imem[0] = 32'h0000_0025;
        pulse_start();
        wait_halt("t2_halt", 20);
        chk("t2_addr1", log_at(1), 37);
        chk("t2_icount", icount, 1);
        chk("t2_units", alu_n + mem_n, 0);

        // 3: PC wraps 63 -> 0 after an ALU op
        do_reset();
        imem[0]  = 32'h0000_003F;
        imem[63] = 32'h4000_0000;
        alu_dly  = 1;
        pulse_start();
        n = 0;
        while (fetch_log.size() < 3 && n < 30) begin
            step();
            n++;
        end
        chk("t3_addr1", log_at(1), 63);
        chk("t3_addr2", log_at(2), 0);
        chk("t3_icount", icount, 2);

        // 4: illegal halts, start restarts at PC 0
        do_reset();
        imem[0] = 32'h0000_0001;
        pulse_start();
        wait_halt("t4_halt", 20);
        chk("t4_illegal", illegal, 1);
        chk("t4_busy", busy, 0);
        chk("t4_instr", instr, 32'hC000_0000);
        chk("t4_icount", icount, 1);
        chk("t4_timeout", timeout, 0);
        pulse_start();
        chk("t4_ill_clr", illegal, 0);
        chk("t4_halted", halted, 0);
        chk("t4_req", bus.imem_req, 1);
        chk("t4_addr", bus.imem_addr, 0);
        chk("t4_icnt_clr", icount, 0);

        // 5a: ALU never completes -> HALT 256 cycles after the dispatch cycle
        do_reset();
        imem[0] = 32'h4000_0000;
        alu_dly = 0;
        pulse_start();
        step();
        chk("t5_alu_start", bus.alu_start, 1);
        n = 0;
        while (!halted && n < 300) begin
            step();
            n++;
        end
        chk("t5_tmo_cycles", n, 256);
        chk("t5_timeout", timeout, 1);
        chk("t5_illegal", illegal, 0);
        chk("t5_busy", busy, 0);
        chk("t5_icount", icount, 0);

        // 5b: done on the 255th wait cycle wins over the watchdog
        do_reset();
        imem[0] = 32'h4000_0000;
        alu_dly = 255;
        pulse_start();
        step();
        repeat (256) step();
        chk("t5b_timeout", timeout, 0);
        chk("t5b_req", bus.imem_req, 1);
        chk("t5b_addr", bus.imem_addr, 1);
        chk("t5b_icount", icount, 1);
        wait_halt("t5b_halt", 10);
        chk("t5b_tmo_end", timeout, 0);
        chk("t5b_illegal", illegal, 1);

        // 6: async reset in WAIT_MEM, then stray done in FETCH
        do_reset();
        imem[0] = 32'h0000_0001;
        imem[1] = 32'h8000_0000;
        mem_dly = 0;
        pulse_start();
        repeat (3) step();
        chk("t6_mem_start", bus.mem_start, 1);
        step();
        chk("t6_busy", busy, 1);
        chk("t6_icount", icount, 1);
        chk("t6_instr", instr, 32'h8000_0000);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_arst");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        ack_en = 1'b0;
        pulse_start();
        mem_stray = 1'b1;
        alu_stray = 1'b1;
        repeat (4) step();
        chk("t6_stray_req", bus.imem_req, 1);
        chk("t6_stray_addr", bus.imem_addr, 0);
        chk("t6_stray_icnt", icount, 0);
        alu_stray = 1'b0;
        imem[0]   = 32'h4000_0000;
        alu_dly   = 3;
        ack_en    = 1'b1;
        step();
        chk("t6_alu_start", bus.alu_start, 1);
        repeat (2) step();
        chk("t6_mem_ignored", bus.imem_req, 0);
        repeat (2) step();
        chk("t6_refetch", bus.imem_req, 1);
        chk("t6_addr1", bus.imem_addr, 1);
        chk("t6_icount_end", icount, 1);
        mem_stray = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
